io_input_dev: RTL

Memory-mapped input device for KEY and SW that sits directly upstream of the data-memory/IO decoder in the single-cycle CPU. It synchronizes and debounces the raw board inputs and latches stable values into data registers. It tracks new-data (Ready) and lost-data (Overrun) status per device and raises a level interrupt request when enabled. The data-memory read mux selects `rdata` whenever `sel` is high.

---
 rtl/io_dev_pkg.sv | 33 +++
 rtl/io_debounce.sv | 58 +++++
 rtl/io_input_dev.sv | 104 ++++++++++
 3 files changed

// File: rtl/io_dev_pkg.sv
// Shared constants, per-device status type and status update rule for the KEY/SW input device.
package io_dev_pkg;

    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 2;
    localparam int unsigned IE_BIT      = 8;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } dev_status_t;

    // A read that coincides with a new value consumed the old one, so it is not an overrun.
    function automatic dev_status_t next_status(input dev_status_t st, input logic changed,
                                                input logic data_rd, input logic ctrl_wr,
                                                input logic wr_overrun, input logic wr_ie);
        dev_status_t nx;
        nx = st;
        if (data_rd) nx.ready = 1'b0;
        if (changed) nx.ready = 1'b1;
        if (ctrl_wr && !wr_overrun) nx.overrun = 1'b0;
        if (changed && st.ready && !data_rd) nx.overrun = 1'b1;
        if (ctrl_wr) nx.ie = wr_ie;
        return nx;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; pulses `changed` when stable updates.
module io_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync0_q, sync0_d, sync1_q, sync1_d;
    logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sync0_d  = din;
        sync1_d  = sync0_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        changed  = 1'b0;
        if (sync1_q != cand_q) begin
            cand_d = sync1_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_q == CNT_MAX) && (cand_q != stable_q)) begin
            stable_d = cand_q;
            changed  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q  <= RESET_VAL;
            sync1_q  <= RESET_VAL;
            cand_q   <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync0_q  <= sync0_d;
            sync1_q  <= sync1_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_input_dev.sv
// Memory-mapped KEY/SW input device: address decode, Ready/Overrun/IE status, read mux and irqs.
module io_input_dev
    import io_dev_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] ADDR_KDATA = DBITS'(KDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_KCTRL = DBITS'(KCTRL_ADDR),
    parameter logic [DBITS-1:0] ADDR_SDATA = DBITS'(SDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_SCTRL = DBITS'(SCTRL_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    output logic             irq_key,
    output logic             irq_sw
);

    logic [3:0] key_stable, key_pressed;
    logic [9:0] sw_stable;
    logic       key_changed, sw_changed;

    // KEY is active-low, so its synchronizer and stable value idle at all-ones.
    io_debounce #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (4'hF)
    ) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .din    (KEY),
        .stable (key_stable),
        .changed(key_changed)
    );

    io_debounce #(
        .WIDTH          (10),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (10'h000)
    ) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .din    (SW),
        .stable (sw_stable),
        .changed(sw_changed)
    );

    logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    dev_status_t key_st_q, key_st_d, sw_st_q, sw_st_d;
    logic unused_wdata;

    assign hit_kdata    = (addr == ADDR_KDATA);
    assign hit_kctrl    = (addr == ADDR_KCTRL);
    assign hit_sdata    = (addr == ADDR_SDATA);
    assign hit_sctrl    = (addr == ADDR_SCTRL);
    assign sel          = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
    assign key_pressed  = ~key_stable;
    assign unused_wdata = ^wdata;

    function automatic logic [DBITS-1:0] ctrl_word(input dev_status_t st);
        logic [DBITS-1:0] w;
        w              = '0;
        w[READY_BIT]   = st.ready;
        w[OVERRUN_BIT] = st.overrun;
        w[IE_BIT]      = st.ie;
        return w;
    endfunction

    always_comb begin
        key_st_d = next_status(key_st_q, key_changed, rd_en & hit_kdata, wr_en & hit_kctrl,
                               wdata[OVERRUN_BIT], wdata[IE_BIT]);
        sw_st_d  = next_status(sw_st_q, sw_changed, rd_en & hit_sdata, wr_en & hit_sctrl,
                               wdata[OVERRUN_BIT], wdata[IE_BIT]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_st_q <= '0;
            sw_st_q  <= '0;
        end else begin
            key_st_q <= key_st_d;
            sw_st_q  <= sw_st_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_kdata)      rdata = DBITS'(key_pressed);
        else if (hit_kctrl) rdata = ctrl_word(key_st_q);
        else if (hit_sdata) rdata = DBITS'(sw_stable);
        else if (hit_sctrl) rdata = ctrl_word(sw_st_q);
    end

    assign irq_key = key_st_q.ready & key_st_q.ie;
    assign irq_sw  = sw_st_q.ready & sw_st_q.ie;

endmodule
